kbd_fifo: RTL
=============

Name: kbd_fifo

Overview:
- Parametrised keyboard scancode buffer between the PS/2 receiver (ps2_data/ps2_hit) and portctl.
- Each rising edge of ps2_hit captures one scancode into a circular FIFO.
- The CPU pops entries through a port-read strobe, and an interrupt request is raised while data is pending.
- Replaces the single-byte latch, adding configurable depth, data width, overflow policy and a sticky overflow flag.

Parameters:
- WIDTH, 8: scancode width in bits.
- DEPTH_LOG2, 4: log2 of FIFO depth. DEPTH = 2**DEPTH_LOG2 entries; legal range 1..8.
- OVERWRITE, 0: full-FIFO policy. 0 = drop the incoming code; 1 = discard the oldest entry and store the incoming code.

Ports:
- clock, in, 1: system clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- ps2_hit, in, 1: scancode strobe, level signal, edge-detected internally.
- ps2_data, in, WIDTH: scancode, valid while ps2_hit is high.
- rd, in, 1: pop strobe, one cycle per pop (portctl read of the data port).
- clr, in, 1: synchronous flush.
- irq_en, in, 1: interrupt enable.
- dout, out, WIDTH: head entry (show-ahead).
- empty, out, 1: FIFO holds 0 entries.
- full, out, 1: FIFO holds DEPTH entries.
- count, out, DEPTH_LOG2+1: number of entries held.
- overflow, out, 1: sticky flag, set when a code was dropped or overwritten.
- irq, out, 1: interrupt request level.

Behaviour:
- Reset (async, high):
  - Write and read pointers = 0, count = 0, overflow = 0.
  - hit_q = 1, so a ps2_hit held high across reset release produces no push.
  - Resulting outputs: empty = 1, full = 0, irq = 0, dout = 0.
  - Storage array is not reset.
- Push detect: push = ps2_hit & ~hit_q, where hit_q is ps2_hit registered every clock.
  - One push per rising edge, regardless of pulse length.
  - ps2_data is sampled in the same cycle as the detected edge.
- Latency: push detected at edge k gives empty = 0, updated count and, if previously empty, dout = the new code, all visible after edge k.
- Pop: rd high at edge k with count > 0 advances the read pointer and decrements count. The next entry appears on dout after edge k.
- dout:
  - Combinational read of mem[rptr] when count > 0.
  - Forced to 0 when empty.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH with no special case.
- Boundary cases:
  - Pop when empty: ignored; count stays 0, no pointer change.
  - Push when not full: write mem[wptr], wptr+1, count+1.
  - Push when full, OVERWRITE=0: code discarded, overflow set, state otherwise unchanged.
  - Push when full, OVERWRITE=1: write mem[wptr]; wptr+1, rptr+1, count stays DEPTH, overflow set.
  - Push and pop in the same cycle, count = 0: push only (the pop sees empty); count becomes 1.
  - Push and pop in the same cycle, 0 < count < DEPTH: both occur; count unchanged.
  - Push and pop in the same cycle, count = DEPTH: both occur in either mode; count stays DEPTH, overflow NOT set.
- clr:
  - Synchronous. Pointers = 0, count = 0, overflow = 0.
  - Has priority over push and pop in the same cycle; a push coincident with clr is lost.
  - hit_q still updates, so the same edge is not re-detected.
- irq:
  - irq = irq_en & (count != 0), combinational from registered state.
  - Stays high while entries remain, drops the cycle after the last pop.
  - Unaffected by overflow.
- full = (count == DEPTH); empty = (count == 0).
- Reset asserted mid-operation aborts everything immediately (async). No partial write is allowed to corrupt the pointers.

Test Plan:
- Reset release with ps2_hit held high, then ps2_hit=0 for 1 cycle, then ps2_data=0x1C with ps2_hit high for 5 cycles -> no push at release, exactly one push: count=1, dout=0x1C, irq=1 (irq_en=1).
- Push 0x01..0x10 at DEPTH_LOG2=4, OVERWRITE=0, then push 0x11 -> full=1, count=16, overflow=1; 16 pops return 0x01..0x10 in order; empty=1, dout=0, irq=0.
- Same fill with OVERWRITE=1, then push 0x11 and 0x12 -> count=16, overflow=1; pops return 0x03..0x12.
- Full FIFO, push 0x55 and rd in the same cycle -> count stays 16, overflow stays 0, dout advances to the second entry, 0x55 is popped last.
- Empty FIFO, push 0x2A and rd in the same cycle -> count=1, dout=0x2A. Then rd twice -> count=0, second pop ignored, count does not underflow.
- Three entries with overflow=1, assert clr concurrently with a push edge -> count=0, overflow=0, empty=1, irq=0; the coincident code is not stored. Asserting reset mid-fill returns all outputs to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO: captures one code per ps2_hit rising edge, pops on rd,
// show-ahead dout; full policy selectable (drop incoming or overwrite oldest).
module kbd_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ps2_hit,
  input  logic [WIDTH-1:0]      ps2_data,
  input  logic                  rd,
  input  logic                  clr,
  input  logic                  irq_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_hit_q;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_write;
  logic w_rd_adv;
  logic w_inc;
  logic w_dec;
  logic w_ovf;

  assign w_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = ps2_hit & ~r_hit_q;
  assign w_pop   = rd & ~w_empty;

  // A pop alongside a push into a full FIFO frees the slot, so both proceed in either mode.
  assign w_write  = w_push & (~w_full | w_pop | OVERWRITE);
  assign w_rd_adv = w_pop | (w_push & w_full & OVERWRITE);
  assign w_inc    = w_push & ~w_full & ~w_pop;
  assign w_dec    = w_pop & ~w_push;
  assign w_ovf    = w_push & w_full & ~w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hit_q    <= 1'b1;
    end else begin
      r_hit_q <= ps2_hit;
      if (clr) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_write)  r_wptr <= r_wptr + DEPTH_LOG2'(1);
        if (w_rd_adv) r_rptr <= r_rptr + DEPTH_LOG2'(1);
        if (w_inc)
          r_count <= r_count + (DEPTH_LOG2+1)'(1);
        else if (w_dec)
          r_count <= r_count - (DEPTH_LOG2+1)'(1);
        if (w_ovf) r_overflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (w_write & ~clr & ~reset) r_mem[r_wptr] <= ps2_data;
  end

  assign dout     = w_empty ? '0 : r_mem[r_rptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign irq      = irq_en & ~w_empty;

endmodule
